// File: rtl/switch_mcu_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// switch_mcu_ahb_arbiter
// Shares the core's single AHB-Lite master port between instruction fetch
// (IFU, requester 0) and load/store (LSU, requester 1). LSU normally wins.
// A starvation counter forces an IFU grant after IFU_MAX_WAIT consecutive
// LSU grants while IFU waits. Each grant becomes one non-pipelined
// SINGLE/NONSEQ transfer: IDLE -> ADDR -> DATA -> IDLE.
//
// Ports
//   in_clk, in_rst          clock and synchronous active-low reset
//   in_init_done            gates new grants; does not abort a transfer
//   in_ifu_*                IFU request, address
//   out_ifu_*               IFU read data, done pulse, error flag
//   in_lsu_*                LSU request, address, write, size, store data
//   out_lsu_*               LSU read data, done pulse, error flag
//   in_hready/hresp/hrdata  AHB slave response
//   out_h*                  AHB master address/control/write data
// ---------------------------------------------------------------------------
module switch_mcu_ahb_arbiter #(
    parameter int unsigned IFU_MAX_WAIT = 4,
    parameter logic [3:0]  HPROT_IFU    = 4'b0010,
    parameter logic [3:0]  HPROT_LSU    = 4'b0011
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_init_done,
    input  logic        in_ifu_req,
    input  logic [31:0] in_ifu_addr,
    output logic [31:0] out_ifu_rdata,
    output logic        out_ifu_done,
    output logic        out_ifu_err,
    input  logic        in_lsu_req,
    input  logic [31:0] in_lsu_addr,
    input  logic        in_lsu_write,
    input  logic [2:0]  in_lsu_size,
    input  logic [31:0] in_lsu_wdata,
    output logic [31:0] out_lsu_rdata,
    output logic        out_lsu_done,
    output logic        out_lsu_err,
    input  logic        in_hready,
    input  logic        in_hresp,
    input  logic [31:0] in_hrdata,
    output logic [31:0] out_haddr,
    output logic        out_hwrite,
    output logic [3:0]  out_hsize,
    output logic [3:0]  out_hport,
    output logic [2:0]  out_hburst,
    output logic [1:0]  out_htrans,
    output logic        out_hmastlock,
    output logic [31:0] out_hwdata
);

    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_ADDR       = 2'b01;
    localparam logic [1:0] ST_DATA       = 2'b10;

    localparam logic [1:0] OWN_NONE      = 2'b00;
    localparam logic [1:0] OWN_IFU       = 2'b01;
    localparam logic [1:0] OWN_LSU       = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [3:0] MAX_WAIT      = IFU_MAX_WAIT[3:0];

    logic [1:0]  state_r;
    logic [1:0]  owner_r;
    logic [3:0]  wait_cnt_r;
    logic [31:0] wdata_r;
    logic        grant_ifu_s;
    logic        grant_lsu_s;

    // Burst type and bus locking are never used by this master.
    assign out_hburst    = 3'b000;
    assign out_hmastlock = 1'b0;

    // Arbitration: only evaluated in IDLE with init complete; LSU priority
    // unless IFU has waited through MAX_WAIT LSU grants.
    always_comb begin
        grant_ifu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if ((state_r == ST_IDLE) && in_init_done) begin
            if (in_ifu_req && in_lsu_req) begin
                if (wait_cnt_r == MAX_WAIT) begin
                    grant_ifu_s = 1'b1;
                end else begin
                    grant_lsu_s = 1'b1;
                end
            end else if (in_ifu_req) begin
                grant_ifu_s = 1'b1;
            end else if (in_lsu_req) begin
                grant_lsu_s = 1'b1;
            end else begin
                grant_ifu_s = 1'b0;
            end
        end else begin
            grant_ifu_s = 1'b0;
        end
    end

    // IFU starvation counter: counts LSU grants won over a pending IFU.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            wait_cnt_r <= 4'd0;
        end else if (!in_ifu_req || grant_ifu_s) begin
            wait_cnt_r <= 4'd0;
        end else if (grant_lsu_s && (wait_cnt_r != MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Transfer sequencer: latches the winner at grant, drives the address
    // phase, then the data phase, and returns the response to the owner.
    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_NONE;
            wdata_r       <= 32'h0000_0000;
            out_htrans    <= HTRANS_IDLE;
            out_haddr     <= 32'h0000_0000;
            out_hwrite    <= 1'b0;
            out_hsize     <= 4'd0;
            out_hport     <= 4'd0;
            out_hwdata    <= 32'h0000_0000;
            out_ifu_rdata <= 32'h0000_0000;
            out_ifu_done  <= 1'b0;
            out_ifu_err   <= 1'b0;
            out_lsu_rdata <= 32'h0000_0000;
            out_lsu_done  <= 1'b0;
            out_lsu_err   <= 1'b0;
        end else begin
            // Done/err are single-cycle pulses unless set below.
            out_ifu_done <= 1'b0;
            out_ifu_err  <= 1'b0;
            out_lsu_done <= 1'b0;
            out_lsu_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_ifu_s) begin
                        state_r    <= ST_ADDR;
                        owner_r    <= OWN_IFU;
                        out_htrans <= HTRANS_NONSEQ;
                        out_haddr  <= in_ifu_addr;
                        out_hwrite <= 1'b0;
                        out_hsize  <= 4'b0010;
                        out_hport  <= HPROT_IFU;
                        wdata_r    <= 32'h0000_0000;
                    end else if (grant_lsu_s) begin
                        state_r    <= ST_ADDR;
                        owner_r    <= OWN_LSU;
                        out_htrans <= HTRANS_NONSEQ;
                        out_haddr  <= in_lsu_addr;
                        out_hwrite <= in_lsu_write;
                        out_hsize  <= {1'b0, in_lsu_size};
                        out_hport  <= HPROT_LSU;
                        // Reads put zero on HWDATA during the data phase.
                        wdata_r    <= in_lsu_write ? in_lsu_wdata : 32'h0000_0000;
                    end else begin
                        state_r    <= ST_IDLE;
                        out_htrans <= HTRANS_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (in_hready) begin
                        state_r    <= ST_DATA;
                        out_htrans <= HTRANS_IDLE;
                        out_hwdata <= wdata_r;
                    end else begin
                        state_r    <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    // HRESP is only sampled with HREADY, so the first cycle
                    // of a two-cycle ERROR response is naturally ignored.
                    if (in_hready) begin
                        state_r    <= ST_IDLE;
                        owner_r    <= OWN_NONE;
                        out_hwdata <= 32'h0000_0000;
                        case (owner_r)
                            OWN_IFU: begin
                                out_ifu_rdata <= in_hrdata;
                                out_ifu_done  <= 1'b1;
                                out_ifu_err   <= in_hresp;
                            end
                            OWN_LSU: begin
                                out_lsu_rdata <= in_hrdata;
                                out_lsu_done  <= 1'b1;
                                out_lsu_err   <= in_hresp;
                            end
                            default: begin
                                out_ifu_done  <= 1'b0;
                                out_lsu_done  <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    owner_r    <= OWN_NONE;
                    out_htrans <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/switch_mcu_ahb_arbiter.md
Name: switch_mcu_ahb_arbiter

Overview:
Shares the core's single AHB-Lite master port between two requesters: instruction fetch (IFU, requester 0) and load/store (LSU, requester 1).
- Arbitrates with LSU priority and a bounded IFU-starvation counter.
- Sequences each granted request as one non-pipelined SINGLE/NONSEQ transfer.
- Returns read data, a done pulse and an error flag to the winning requester.
- Sits between switch_mcu_ifu / LSU and the external AHB bus.

Parameters:
- IFU_MAX_WAIT, 4: consecutive LSU grants allowed while IFU is pending before IFU is forced to win (1..15).
- HPROT_IFU, 4'b0010: out_hport value for IFU transfers (opcode fetch, privileged).
- HPROT_LSU, 4'b0011: out_hport value for LSU transfers (data, privileged).

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_rst  input  1  synchronous active-low reset.
- in_init_done  input  1  no grants are issued while 0.
- in_ifu_req  input  1  IFU request; held with its fields until out_ifu_done.
- in_ifu_addr  input  32  IFU fetch address.
- out_ifu_rdata  output  32  fetched word; valid with out_ifu_done.
- out_ifu_done  output  1  one-cycle completion pulse.
- out_ifu_err  output  1  high with out_ifu_done when the bus returned ERROR.
- in_lsu_req  input  1  LSU request; held until out_lsu_done.
- in_lsu_addr  input  32  LSU address.
- in_lsu_write  input  1  1 = store.
- in_lsu_size  input  3  HSIZE code: 0 byte, 1 half, 2 word.
- in_lsu_wdata  input  32  store data, bus-lane aligned.
- out_lsu_rdata  output  32  load data; valid with out_lsu_done.
- out_lsu_done  output  1  one-cycle completion pulse.
- out_lsu_err  output  1  error flag with out_lsu_done.
- in_hready  input  1  AHB HREADY.
- in_hresp  input  1  AHB HRESP (1 = ERROR).
- in_hrdata  input  32  AHB HRDATA.
- out_haddr  output  32  AHB HADDR.
- out_hwrite  output  1  AHB HWRITE.
- out_hsize  output  4  AHB HSIZE; bit 3 is always 0.
- out_hport  output  4  AHB HPROT.
- out_hburst  output  3  constant 3'b000 (SINGLE).
- out_htrans  output  2  AHB HTRANS.
- out_hmastlock  output  1  constant 0.
- out_hwdata  output  32  AHB HWDATA.

Behaviour:
Clock, reset and reset values:
- One clock, in_clk. Reset in_rst is synchronous, active-low.
- With in_rst=0 at a rising edge: state=IDLE, out_htrans=2'b00, out_haddr=0, out_hwrite=0, out_hsize=0, out_hport=0, out_hwdata=0, all done/err/rdata outputs=0, starvation counter=0, grant owner=none.

State machine: IDLE, ADDR, DATA.
- IDLE: if in_init_done=1 and any request is high, arbitrate, latch the winner's addr/write/size/wdata/hprot and go to ADDR.
  - IFU transfers use write=0, size=3'b010.
- ADDR: out_htrans=2'b10 (NONSEQ) with the latched address/control.
  - If in_hready=1: go to DATA, out_htrans becomes 2'b00.
  - Otherwise hold ADDR with all outputs stable.
- DATA: out_htrans=2'b00; out_hwdata carries the latched wdata (0 for reads).
  - When in_hready=1: register in_hrdata into the owner's rdata, pulse the owner's done for exactly one cycle next cycle, set err=in_hresp, go to IDLE.
  - in_hresp=1 with in_hready=0 (first ERROR cycle) is ignored.

Arbitration (IDLE only):
- Only IFU requesting: IFU wins. Only LSU requesting: LSU wins.
- Both requesting: LSU wins unless the counter equals IFU_MAX_WAIT, in which case IFU wins.
- Counter increments on each LSU grant while in_ifu_req=1, saturating at IFU_MAX_WAIT.
- Counter clears on an IFU grant or when in_ifu_req=0.

Timing and handshake:
- Latency: request seen in IDLE at cycle t -> ADDR at t+1 -> DATA at t+2 (zero wait) -> done at t+3.
- Each HREADY wait cycle adds one cycle.
- The IDLE cycle following done re-arbitrates; minimum spacing is 3 cycles per transfer.
- rdata registers hold their value until the next completion for the same requester.
- Requester inputs are sampled only at grant; changes after grant are ignored.
- A requester dropping req mid-transfer does not abort the transfer; its done still pulses.

Reset and init:
- Reset mid-transfer abandons the transfer immediately: no done pulse, bus returns to IDLE the next cycle.
- in_init_done falling mid-transfer does not abort; it only blocks new grants.

Test Plan:
- IFU-only read, addr 0x0000_0100, hrdata 0x0000_0013, hready=1 throughout -> htrans NONSEQ at t+1, out_ifu_done=1 at t+3, out_ifu_rdata=0x0000_0013, out_hport=4'b0010, out_hsize=4'b0010.
- LSU store sb, addr 0x2000_0003, wdata 0xAB00_0000, two HREADY-low cycles in DATA -> out_hwrite=1, out_hsize=0, out_hwdata=0xAB00_0000, out_lsu_done at t+5, err=0.
- Both requesting continuously, IFU_MAX_WAIT=4 -> grant order LSU×4, IFU, LSU×4, IFU; counter never exceeds 4.
- LSU load gets two-cycle ERROR (hresp=1/hready=0, then hresp=1/hready=1) -> single out_lsu_done with out_lsu_err=1; next transfer has err=0.
- in_rst=0 asserted while in DATA -> next cycle out_htrans=0, no done pulse; with in_init_done=0 and requests high, no NONSEQ is issued.
